// File: rtl/ibex_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ibex_fetch_pkg
//
// Purpose: shared types and helpers for the fetch align FIFO and its
// combinational realignment stage.
//
// Contents:
//   OPC_MASK_C     - the low two opcode bits that mark a 32-bit instruction
//   fetch_entry_t  - one stored bus word plus its bus-error flag
//   is_compressed  - length decode of a 16-bit instruction parcel
// ---------------------------------------------------------------------------
package ibex_fetch_pkg;

   localparam logic [1:0] OPC_MASK_C = 2'b11;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } fetch_entry_t;

   // Any parcel whose low two bits are not both set is a 16-bit instruction.
   function automatic logic is_compressed(input logic [15:0] parcel);
      return (parcel[1:0] & OPC_MASK_C) != OPC_MASK_C;
   endfunction

endpackage

// File: rtl/ibex_fetch_align.sv
// ---------------------------------------------------------------------------
// ibex_fetch_align
//
// Purpose: purely combinational realignment of the two oldest FIFO words
// into one whole 16-bit or 32-bit instruction, plus the bookkeeping the
// FIFO needs to pop it.
//
// Optional feature: define IBEX_FETCH_FIFO_ERR_EN to honour the per-word
// bus-error flags; otherwise the err outputs are tied low.
//
// Ports:
//   word0_i, word1_i   in   entries at rptr and rptr+1
//   has_one_i          in   count >= 1
//   has_two_i          in   count >= 2
//   half_i             in   PC bit 1 (instruction starts in upper half)
//   rdata_o            out  aligned instruction
//   valid_o            out  a complete instruction is available
//   adv_o              out  PC increment, 2 or 4
//   free_o             out  one word is released on pop
//   err_o              out  instruction touches an errored word
//   err_plus2_o        out  error only in the second word
// ---------------------------------------------------------------------------
module ibex_fetch_align
   import ibex_fetch_pkg::*;
(
   input  fetch_entry_t word0_i,
   input  fetch_entry_t word1_i,
   input  logic         has_one_i,
   input  logic         has_two_i,
   input  logic         half_i,
   output logic [31:0]  rdata_o,
   output logic         valid_o,
   output logic [2:0]   adv_o,
   output logic         free_o,
   output logic         err_o,
   output logic         err_plus2_o
);

   logic compressed;

   // An unaligned instruction takes its low parcel from the top of word0.
   // Only an aligned compressed instruction leaves word0 partly unconsumed;
   // every other shape releases exactly one word, and for unaligned 32-bit
   // instructions the upper half of word1 becomes the next unaligned parcel.
   always_comb begin
      rdata_o     = half_i ? {word1_i.rdata[15:0], word0_i.rdata[31:16]} : word0_i.rdata;
      compressed  = is_compressed(rdata_o[15:0]);
      valid_o     = (half_i && !compressed) ? has_two_i : has_one_i;
      adv_o       = compressed ? 3'd2 : 3'd4;
      free_o      = half_i || !compressed;
      err_o       = 1'b0;
      err_plus2_o = 1'b0;
`ifdef IBEX_FETCH_FIFO_ERR_EN
      // A bad word0 cannot be length-decoded, so it is emitted as soon as
      // it exists and retired like an aligned 32-bit instruction.
      if (has_one_i && word0_i.err) begin
         valid_o = 1'b1;
         adv_o   = 3'd4;
         free_o  = 1'b1;
         err_o   = 1'b1;
      end else if (half_i && !compressed && has_two_i && word1_i.err) begin
         err_o       = 1'b1;
         err_plus2_o = 1'b1;
      end
`endif
   end

`ifdef IBEX_FETCH_FIFO_ERR_EN
   logic unused_upper;
   assign unused_upper = ^word1_i.rdata[31:16];
`else
   logic unused_upper;
   assign unused_upper = ^{word1_i.rdata[31:16], word0_i.err, word1_i.err};
`endif

endmodule

// File: rtl/ibex_fetch_align_fifo.sv
// ---------------------------------------------------------------------------
// ibex_fetch_align_fifo
//
// Purpose: prefetch buffer feeding the static branch predictor. Stores
// 32-bit instruction-bus words in a small circular buffer and presents
// whole 16/32-bit instructions with their PC. Flushed and re-pointed by
// clear_i on any redirect.
//
// Optional feature: define IBEX_FETCH_FIFO_ERR_EN to store in_err_i per
// entry and report it on out_err_o / out_err_plus2_o.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   clear_i/clear_addr_i  flush and load new PC (bit 0 forced to 0)
//   in_valid_i/in_rdata_i/in_err_i/in_ready_o  word push handshake
//   busy_o                count >= DEPTH-1, fetch stops issuing requests
//   out_valid_o/out_ready_i/out_rdata_o/out_addr_o  instruction handshake
//   out_err_o/out_err_plus2_o  bus error flags for the instruction
// ---------------------------------------------------------------------------
module ibex_fetch_align_fifo #(
   parameter int unsigned DEPTH = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic [31:0] clear_addr_i,
   input  logic        in_valid_i,
   input  logic [31:0] in_rdata_i,
   input  logic        in_err_i,
   output logic        in_ready_o,
   output logic        busy_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_rdata_o,
   output logic [31:0] out_addr_o,
   output logic        out_err_o,
   output logic        out_err_plus2_o
);
   import ibex_fetch_pkg::*;

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [31:0]      rdata_q [DEPTH];
   logic [31:0]      rdata_d [DEPTH];
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      addr_q, addr_d;

   logic [PTR_W-1:0] rptr_next;
   fetch_entry_t     word0, word1;
   logic             push, pop, pop_free;
   logic [2:0]       adv;
   logic             free;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign rptr_next  = ptr_inc(rptr_q);
   assign in_ready_o = count_q < CNT_W'(DEPTH);
   assign busy_o     = count_q >= CNT_W'(DEPTH - 1);
   assign out_addr_o = addr_q;

`ifdef IBEX_FETCH_FIFO_ERR_EN
   logic err_q [DEPTH];
   logic err_d [DEPTH];
`else
   logic unused_in_err;
   assign unused_in_err = in_err_i;
`endif

   // Assemble the two oldest entries for the aligner; without error
   // support there is no err storage and the flags read as clean.
   always_comb begin
      word0.rdata = rdata_q[rptr_q];
      word1.rdata = rdata_q[rptr_next];
      word0.err   = 1'b0;
      word1.err   = 1'b0;
`ifdef IBEX_FETCH_FIFO_ERR_EN
      word0.err   = err_q[rptr_q];
      word1.err   = err_q[rptr_next];
`endif
   end

   ibex_fetch_align u_align (
      .word0_i     (word0),
      .word1_i     (word1),
      .has_one_i   (count_q != '0),
      .has_two_i   (count_q >= CNT_W'(2)),
      .half_i      (addr_q[1]),
      .rdata_o     (out_rdata_o),
      .valid_o     (out_valid_o),
      .adv_o       (adv),
      .free_o      (free),
      .err_o       (out_err_o),
      .err_plus2_o (out_err_plus2_o)
   );

   assign push     = in_valid_i && in_ready_o;
   assign pop      = out_valid_o && out_ready_i;
   assign pop_free = pop && free;

   // Next-state: clear wins over any same-cycle push or pop. Readiness is
   // taken from the current count, so a pop never makes room for a push
   // in the same cycle.
   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
`ifdef IBEX_FETCH_FIFO_ERR_EN
      err_d   = err_q;
`endif
      if (clear_i) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
         addr_d  = {clear_addr_i[31:1], 1'b0};
      end else begin
         if (push) begin
            rdata_d[wptr_q] = in_rdata_i;
`ifdef IBEX_FETCH_FIFO_ERR_EN
            err_d[wptr_q]   = in_err_i;
`endif
            wptr_d = ptr_inc(wptr_q);
         end
         if (pop) begin
            addr_d = addr_q + 32'(adv);
            if (free) begin
               rptr_d = rptr_next;
            end
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop_free);
      end
   end

   // Control state carries the reset; the data array does not need one
   // because nothing is read from it while count is zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         addr_q  <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         addr_q  <= addr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      rdata_q <= rdata_d;
`ifdef IBEX_FETCH_FIFO_ERR_EN
      err_q   <= err_d;
`endif
   end

   // Offering a word while full is an upstream protocol error; the word
   // is dropped.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !clear_i) begin
         push_while_full_a: assert (!(in_valid_i && !in_ready_o));
      end
   end

endmodule
